// File: rtl/shift_add_mult8_pkg.sv
// Shared constants and state encoding for the shift-add multiplier.
// Operand width is fixed by the ripple-carry adder it drives.
package shift_add_mult8_pkg;

  localparam int WIDTH  = 8;
  localparam int PROD_W = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/shift_add_mult8_adder.sv
// The 8-bit ripple-carry adder used by the multiplier: a chain of full adders.
// The adder contains no clocked logic.
module FA (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module BinaryAdder8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [8:0] carry;

  assign carry[0] = cin;
  assign cout     = carry[8];

  for (genvar i = 0; i < 8; i++) begin : g_fa
    FA fa_i (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

endmodule

// File: rtl/shift_add_mult8.sv
// Sequential 8x8 unsigned multiplier: one add-and-shift step per clock through
// the shared ripple-carry adder, with a start/busy/done handshake.
module shift_add_mult8 #(
  parameter int WIDTH = shift_add_mult8_pkg::WIDTH,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  import shift_add_mult8_pkg::*;

  state_t             state, stateNext;
  logic [WIDTH-1:0]   m, acc, q;
  logic               c;
  logic [CNT_W-1:0]   cnt;

  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic               cStep;
  logic [WIDTH-1:0]   tStep;
  logic [WIDTH-1:0]   accNext, qNext;

  BinaryAdder8bit adder (
    .a    (acc),
    .b    (m),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // The carry re-enters ACC through the right shift, so nothing is lost.
  always_comb begin
    cStep = 1'b0;
    tStep = acc;
    if (q[0]) begin
      cStep = cout;
      tStep = sum;
    end
    accNext = {cStep, tStep[WIDTH-1:1]};
    qNext   = {tStep[0], q[WIDTH-1:1]};
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = RUN;
      RUN:     if (cnt == CNT_W'(WIDTH - 1)) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      m       <= '0;
      acc     <= '0;
      q       <= '0;
      c       <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: begin
          if (start) begin
            m   <= a;
            q   <= b;
            acc <= '0;
            c   <= 1'b0;
            cnt <= '0;
          end
        end
        RUN: begin
          acc <= accNext;
          q   <= qNext;
          c   <= cStep;
          cnt <= cnt + 1'b1;
          // Product is captured from the final step as DONE is entered.
          if (stateNext == DONE) product <= {accNext, qNext};
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_shift_add_mult8.sv
// Directed self-checking bench for shift_add_mult8 with hand-computed products.
// Outputs are sampled on the falling edge, inputs driven there as well.
module tb_shift_add_mult8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  a, b;
  logic        busy, done;
  logic [15:0] product;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  int busyCyc, doneCnt, doneAt;

  shift_add_mult8 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    a     = x;
    b     = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Walks one operation from the cycle after the start edge until busy drops.
  // With poke set, start is pulsed (new operands) in RUN cycle 3 and in DONE.
  task automatic observeOp(input bit poke);
    busyCyc = 0;
    doneCnt = 0;
    doneAt  = 0;
    while (busy === 1'b1 && busyCyc < 20) begin
      busyCyc++;
      if (done === 1'b1) begin
        doneCnt++;
        doneAt = busyCyc;
      end
      start = poke && (busyCyc == 3 || done === 1'b1);
      if (start) begin
        a = 8'hAA;
        b = 8'h55;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic runOp(input string tag, input logic [7:0] x, input logic [7:0] y,
                       input logic [15:0] expProd);
    applyStimulus(x, y);
    observeOp(1'b0);
    checkOutput({tag, " busyCycles"}, busyCyc, 9);
    checkOutput({tag, " doneCount"}, doneCnt, 1);
    checkOutput({tag, " doneAt"}, doneAt, 9);
    checkOutput({tag, " product"}, product, expProd);
    @(negedge clk);
    checkOutput({tag, " productHold"}, product, expProd);
  endtask

  initial begin
    int cyc, firstDone, secondDone;
    logic [15:0] firstProd, secondProd;

    rst_n = 1'b0;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;

    // Reset, then idle with no activity.
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset product", product, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("idle busy", busy, 0);
      checkOutput("idle product", product, 16'h0000);
    end

    runOp("basic 0Dx0B", 8'h0D, 8'h0B, 16'h008F);
    runOp("max FFxFF", 8'hFF, 8'hFF, 16'hFE01);
    runOp("80x02", 8'h80, 8'h02, 16'h0100);
    runOp("zero 00xFF", 8'h00, 8'hFF, 16'h0000);

    // Start requests while busy must be ignored.
    applyStimulus(8'h03, 8'h05);
    observeOp(1'b1);
    checkOutput("busyStart busyCycles", busyCyc, 9);
    checkOutput("busyStart doneCount", doneCnt, 1);
    checkOutput("busyStart product", product, 16'h000F);
    repeat (2) @(negedge clk);
    checkOutput("busyStart idleAfter", busy, 0);

    // Reset in RUN cycle 4 aborts the operation.
    applyStimulus(8'hFF, 8'hFF);
    doneCnt = 0;
    repeat (3) begin
      if (done === 1'b1) doneCnt++;
      @(negedge clk);
    end
    checkOutput("abort busyBefore", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("abort busy", busy, 0);
    checkOutput("abort done", done, 0);
    checkOutput("abort product", product, 16'h0000);
    repeat (10) begin
      if (done === 1'b1) doneCnt++;
      @(negedge clk);
    end
    checkOutput("abort noDone", doneCnt, 0);
    runOp("after abort 02x03", 8'h02, 8'h03, 16'h0006);

    // Back-to-back operations with start held high.
    @(negedge clk);
    a          = 8'h10;
    b          = 8'h10;
    start      = 1'b1;
    firstDone  = -1;
    secondDone = -1;
    firstProd  = '0;
    secondProd = '0;
    for (cyc = 0; cyc < 40 && secondDone < 0; cyc++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (firstDone < 0) begin
          firstDone = cyc;
          firstProd = product;
          a = 8'h07;
          b = 8'h09;
        end else begin
          secondDone = cyc;
          secondProd = product;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    checkOutput("b2b firstDoneSeen", (firstDone >= 0), 1);
    checkOutput("b2b secondDoneSeen", (secondDone >= 0), 1);
    checkOutput("b2b spacing", secondDone - firstDone, 10);
    checkOutput("b2b product1", firstProd, 16'h0100);
    checkOutput("b2b product2", secondProd, 16'h003F);

    repeat (12) @(negedge clk);
    checkOutput("final idle", busy, 0);
    checkOutput("final product", product, 16'h003F);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
